gmm_seq_ctrl: RTL and testbench

//  Frame sequencer for the GMM classifier datapath (mean-sub -> vector-matrix mult -> square-acc -> weight-avg).

---
 rtl/gmm_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_gmm_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gmm_seq_ctrl.sv
// GMM frame sequencer: walks (mix,var), aligns g_rst/y_sload/k_sload, drains, pulses done; done at 1+N_MIX*N_VARIABLE+DRAIN cycles after start.
// stall freezes ce and all state (one extra cycle per stall); optional abort input via GMM_SEQ_CTRL_ABORT_EN.

module gmm_seq_dly #(
  parameter int DLY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic adv,
  input  logic din,
  output logic tap
);
  if (DLY == 0) begin : g_wire
    assign tap = din;
  end else begin : g_reg
    logic [DLY-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr <= '0;
      end else if (clr) begin
        sr <= '0;
      end else if (adv) begin
        sr <= (sr << 1) | DLY'(din);
      end
    end

    assign tap = sr[DLY-1];
  end
endmodule

module gmm_seq_ctrl #(
  parameter int N_VARIABLE = 4,
  parameter int N_MIX      = 8,
  parameter int G_DLY      = 1,
  parameter int Y_DLY      = 3,
  parameter int K_DLY      = 6,
  parameter int DRAIN      = 8,
  localparam int MW = (N_MIX > 1) ? $clog2(N_MIX) : 1,
  localparam int VW = (N_VARIABLE > 1) ? $clog2(N_VARIABLE) : 1,
  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
`ifdef GMM_SEQ_CTRL_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  output logic          done,
  output logic          ce,
  output logic          issue_vld,
  output logic [MW-1:0] mix_idx,
  output logic [VW-1:0] var_idx,
  output logic          g_rst,
  output logic          y_sload,
  output logic          k_sload
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] drain_cnt;
  logic          var_last, mix_last, clr;
  logic          mix_first, frame_first;
  logic          g_tap, y_tap, k_tap;

  assign var_last = (var_idx == VW'(N_VARIABLE - 1));
  assign mix_last = (mix_idx == MW'(N_MIX - 1));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    ce        = 1'b0;
    issue_vld = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy      = 1'b1;
        ce        = !stall;
        issue_vld = !stall;
        if (!stall && var_last && mix_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        ce   = !stall;
        if (!stall && drain_cnt == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
`ifdef GMM_SEQ_CTRL_ABORT_EN
    if (abort && (state == S_RUN || state == S_DRAIN)) state_nxt = S_IDLE;
`endif
  end

  // Leaving the active states wipes indices, counter and delay lines.
  assign clr = (state_nxt == S_IDLE) || (state_nxt == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mix_idx <= '0;
      var_idx <= '0;
    end else if (clr) begin
      mix_idx <= '0;
      var_idx <= '0;
    end else if (issue_vld) begin
      if (var_last) begin
        var_idx <= '0;
        mix_idx <= mix_last ? '0 : mix_idx + 1'b1;
      end else begin
        var_idx <= var_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if (clr) begin
      drain_cnt <= '0;
    end else if (state == S_RUN && state_nxt == S_DRAIN) begin
      drain_cnt <= DW'(DRAIN - 1);
    end else if (state == S_DRAIN && ce && drain_cnt != '0) begin
      drain_cnt <= drain_cnt - 1'b1;
    end
  end

  assign mix_first   = issue_vld && (var_idx == '0);
  assign frame_first = mix_first && (mix_idx == '0);

  gmm_seq_dly #(.DLY(G_DLY)) u_g_dly (
    .clk(clk), .rst_n(rst_n), .clr(clr), .adv(ce), .din(mix_first), .tap(g_tap)
  );
  gmm_seq_dly #(.DLY(Y_DLY)) u_y_dly (
    .clk(clk), .rst_n(rst_n), .clr(clr), .adv(ce), .din(mix_first), .tap(y_tap)
  );
  gmm_seq_dly #(.DLY(K_DLY)) u_k_dly (
    .clk(clk), .rst_n(rst_n), .clr(clr), .adv(ce), .din(frame_first), .tap(k_tap)
  );

  assign g_rst   = ce && g_tap;
  assign y_sload = ce && y_tap;
  assign k_sload = ce && k_tap;

endmodule

// File: tb/tb_gmm_seq_ctrl.sv
// Directed bench for gmm_seq_ctrl: table-driven frame vectors plus hand sequences for reset, tiny config and abort.
module tb_gmm_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
`ifdef GMM_SEQ_CTRL_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic       busy, done, ce, issue_vld, g_rst, y_sload, k_sload;
  logic [2:0] mix_idx;
  logic [1:0] var_idx;

  logic       sm_start = 1'b0;
  logic       sm_stall = 1'b0;
`ifdef GMM_SEQ_CTRL_ABORT_EN
  logic       sm_abort = 1'b0;
`endif
  logic       sm_busy, sm_done, sm_ce, sm_issue_vld, sm_g_rst, sm_y_sload, sm_k_sload;
  logic [0:0] sm_mix_idx, sm_var_idx;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gmm_seq_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
`ifdef GMM_SEQ_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .ce(ce), .issue_vld(issue_vld),
    .mix_idx(mix_idx), .var_idx(var_idx),
    .g_rst(g_rst), .y_sload(y_sload), .k_sload(k_sload)
  );

  gmm_seq_ctrl #(
    .N_VARIABLE(1), .N_MIX(1), .G_DLY(0), .Y_DLY(0), .K_DLY(0), .DRAIN(1)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .start(sm_start), .stall(sm_stall),
`ifdef GMM_SEQ_CTRL_ABORT_EN
    .abort(sm_abort),
`endif
    .busy(sm_busy), .done(sm_done), .ce(sm_ce), .issue_vld(sm_issue_vld),
    .mix_idx(sm_mix_idx), .var_idx(sm_var_idx),
    .g_rst(sm_g_rst), .y_sload(sm_y_sload), .k_sload(sm_k_sload)
  );

  typedef struct {
    logic start;
    logic stall;
    logic busy;
    logic done;
    logic ce;
    logic iv;
    int   mix;   // -1: not checked
    int   vr;
    logic g;
    logic y;
    logic k;
  } vec_t;

  vec_t tv[0:63];
  int   tv_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    start = 1'b0;
    stall = 1'b0;
    sm_start = 1'b0;
`ifdef GMM_SEQ_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = -1;
  endtask

  // Expected values come from the nominal frame timeline: issue 1..32, g 2+4m, y 4+4m, k 7, done 41.
  task automatic fill(input int n, input int slo, input int shi, input bit restart);
    tv_n = n;
    for (int c = 0; c < n; c++) begin
      int e;
      tv[c].start = (c == 0) || (restart && (c == 5 || c == 41 || c == 42));
      tv[c].stall = (c >= slo && c <= shi);
      if (tv[c].stall) begin
        tv[c].busy = 1'b1; tv[c].done = 1'b0; tv[c].ce = 1'b0; tv[c].iv = 1'b0;
        tv[c].mix = 2; tv[c].vr = 1;
        tv[c].g = 1'b0; tv[c].y = 1'b0; tv[c].k = 1'b0;
      end else begin
        if (restart && c >= 42) e = c - 42;
        else if (c > shi) e = c - (shi - slo + 1);
        else e = c;
        tv[c].busy = (e >= 1 && e <= 40);
        tv[c].done = (e == 41);
        tv[c].ce   = tv[c].busy;
        tv[c].iv   = (e >= 1 && e <= 32);
        tv[c].mix  = tv[c].iv ? (e - 1) / 4 : -1;
        tv[c].vr   = tv[c].iv ? (e - 1) % 4 : -1;
        tv[c].g    = (e >= 2 && e <= 30 && (e - 2) % 4 == 0);
        tv[c].y    = (e >= 4 && e <= 32 && e % 4 == 0);
        tv[c].k    = (e == 7);
      end
    end
  endtask

  task automatic run_table();
    for (int c = 0; c < tv_n; c++) begin
      tick();
      start = tv[c].start;
      stall = tv[c].stall;
      @(negedge clk);
      chk("busy", busy, tv[c].busy);
      chk("done", done, tv[c].done);
      chk("ce", ce, tv[c].ce);
      chk("issue_vld", issue_vld, tv[c].iv);
      chk("g_rst", g_rst, tv[c].g);
      chk("y_sload", y_sload, tv[c].y);
      chk("k_sload", k_sload, tv[c].k);
      if (tv[c].mix >= 0) begin
        chk("mix_idx", mix_idx, tv[c].mix);
        chk("var_idx", var_idx, tv[c].vr);
      end
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    int dc;
    int ndone;

    // Reset state, with start held high to show it is ignored.
    start = 1'b1;
    sm_start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ce", ce, 0);
    chk("rst_issue", issue_vld, 0);
    chk("rst_mix", mix_idx, 0);
    chk("rst_var", var_idx, 0);
    chk("rst_g", g_rst, 0);
    chk("rst_y", y_sload, 0);
    chk("rst_k", k_sload, 0);
    chk("rst_sm_busy", sm_busy, 0);

    // Nominal frame, then stalled frame, then ignored/accepted restarts.
    do_reset();
    fill(43, 1000, 999, 1'b0);
    run_table();

    do_reset();
    fill(46, 10, 12, 1'b0);
    run_table();

    do_reset();
    fill(46, 1000, 999, 1'b1);
    run_table();

    // Async reset in the middle of a frame, then a clean frame.
    do_reset();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    while (cyc < 15) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ce", ce, 0);
    chk("arst_issue", issue_vld, 0);
    chk("arst_mix", mix_idx, 0);
    chk("arst_var", var_idx, 0);
    chk("arst_strobes", {g_rst, y_sload, k_sload, done}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = -1;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    @(negedge clk);
    chk("post_rst_issue", issue_vld, 1);
    chk("post_rst_mix", mix_idx, 0);
    chk("post_rst_var", var_idx, 0);
    dc = -1;
    for (int i = 0; i < 60 && dc < 0; i++) begin
      tick();
      @(negedge clk);
      if (done) dc = cyc;
    end
    chk("post_rst_done_cycle", dc, 41);

    // Minimal configuration with zero delays.
    do_reset();
    tick(); sm_start = 1'b1;
    tick(); sm_start = 1'b0;
    @(negedge clk);
    chk("sm_issue_c1", sm_issue_vld, 1);
    chk("sm_strobes_c1", {sm_g_rst, sm_y_sload, sm_k_sload}, 3'b111);
    chk("sm_idx_c1", {sm_mix_idx, sm_var_idx}, 0);
    tick();
    @(negedge clk);
    chk("sm_issue_c2", sm_issue_vld, 0);
    chk("sm_busy_c2", sm_busy, 1);
    chk("sm_done_c2", sm_done, 0);
    tick();
    @(negedge clk);
    chk("sm_done_c3", sm_done, 1);
    chk("sm_busy_c3", sm_busy, 0);
    tick();
    @(negedge clk);
    chk("sm_done_c4", sm_done, 0);

`ifdef GMM_SEQ_CTRL_ABORT_EN
    do_reset();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    while (cyc < 20) tick();
    abort = 1'b1;
    tick(); abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_ce", ce, 0);
    chk("abort_issue", issue_vld, 0);
    chk("abort_strobes", {g_rst, y_sload, k_sload}, 0);
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
`else
    ndone = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
